// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 timing unit: T-state codes, front-panel
// mode encodings and the timing FSM state type.
package sap1_pkg;

    localparam logic [5:0] T1     = 6'b100000;
    localparam logic [5:0] T2     = 6'b010000;
    localparam logic [5:0] T3     = 6'b001000;
    localparam logic [5:0] T4     = 6'b000100;
    localparam logic [5:0] T5     = 6'b000010;
    localparam logic [5:0] T6     = 6'b000001;
    localparam logic [5:0] T_IDLE = 6'b000000;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_TSTEP = 2'b01;
    localparam logic [1:0] MODE_ISTEP = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        INSTR_RUN = 2'd1,
        HALTED    = 2'd2
    } sap1_state_t;

    // One T-state forward: the ring moves toward t[0] and T6 wraps to T1.
    function automatic logic [5:0] t_rotate(input logic [5:0] t_cur);
        return {t_cur[0], t_cur[5:1]};
    endfunction

endpackage

// File: rtl/sap1_step_debouncer.sv
// Front-panel step button conditioning: 2-FF synchronizer, stability counter
// and a single-cycle pulse on each accepted rising level.
module sap1_step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic step_btn,
    output logic step_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_ff1;
    logic             sync_ff2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with the
    // accepted level; any sample agreeing with it restarts the count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_ff1   <= 1'b0;
            sync_ff2   <= 1'b0;
            level      <= 1'b0;
            cnt        <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync_ff1   <= step_btn;
            sync_ff2   <= sync_ff1;
            step_pulse <= 1'b0;
            if (sync_ff2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level      <= sync_ff2;
                cnt        <= '0;
                step_pulse <= sync_ff2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sap1_timing_unit.sv
// SAP-1 ring counter producing the one-hot T-state word, with run / T-step /
// instruction-step / hold control, HLT freeze and a retired-instruction count.
module sap1_timing_unit
    import sap1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               LOW_HALT,
    input  logic [1:0]         mode,
    input  logic               step_btn,
    output logic [5:0]         t,
    output logic               halted,
    output logic               step_ready,
    output logic [COUNT_W-1:0] instr_count,
    output sap1_state_t        state_dbg
);

    sap1_state_t        state_q;
    sap1_state_t        state_d;
    logic [5:0]         t_d;
    logic               halted_d;
    logic [COUNT_W-1:0] count_d;
    logic               advance;
    logic               step_pulse;

    sap1_step_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debouncer (
        .clk       (clk),
        .clr       (clr),
        .step_btn  (step_btn),
        .step_pulse(step_pulse)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ACTIVE;
            t           <= T1;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q     <= state_d;
            t           <= t_d;
            halted      <= halted_d;
            instr_count <= count_d;
        end
    end

    // Priority: halt beats a mode abort, which beats the step/run advance.
    always_comb begin
        state_d  = state_q;
        t_d      = t;
        halted_d = halted;
        count_d  = instr_count;
        advance  = 1'b0;
        case (state_q)
            HALTED: begin
                t_d = T_IDLE;
            end
            default: begin
                if (t[2] && !LOW_HALT) begin
                    state_d  = HALTED;
                    t_d      = T_IDLE;
                    halted_d = 1'b1;
                end else begin
                    if (state_q == INSTR_RUN && mode == MODE_ISTEP) begin
                        advance = 1'b1;
                    end else begin
                        // Leaving INSTR_RUN because the mode moved away lands
                        // here, so the new mode's rule applies on this edge.
                        state_d = ACTIVE;
                        case (mode)
                            MODE_RUN:   advance = 1'b1;
                            MODE_TSTEP: advance = step_pulse;
                            MODE_ISTEP: begin
                                if (step_pulse) begin
                                    advance = 1'b1;
                                    state_d = INSTR_RUN;
                                end
                            end
                            default:    advance = 1'b0;
                        endcase
                    end
                    if (advance) begin
                        t_d = t_rotate(t);
                        if (t == T6) begin
                            count_d = instr_count + COUNT_W'(1);
                            state_d = ACTIVE;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        step_ready = ((mode == MODE_TSTEP) ||
                      (mode == MODE_ISTEP && state_q != INSTR_RUN)) && !halted;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_sap1_timing_unit.sv
// Randomized self-checking bench for sap1_timing_unit against a cycle-level
// behavioural model of the T-state ring, step button and halt rules.
module tb_sap1_timing_unit;
    import sap1_pkg::*;

    localparam int D  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          low_halt = 1'b1;
    logic          step_btn = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [5:0]    t;
    logic          halted;
    logic          step_ready;
    logic [CW-1:0] instr_count;
    sap1_state_t   state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] exp_q[$];

    // Reference model state
    int m_tidx;        // 0..5 for T1..T6
    bit m_halted;
    int m_count;
    int m_run_left;    // advances still owed to an instruction-step run
    bit m_level;       // accepted button level
    int m_same;        // consecutive synchronized samples differing from m_level
    bit m_pulse;       // accepted rising edge, usable on the next edge
    bit m_hist[$];     // button values sampled on the last two edges

    sap1_timing_unit #(
        .DEBOUNCE_CYCLES(D),
        .COUNT_W        (CW)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .LOW_HALT   (low_halt),
        .mode       (mode),
        .step_btn   (step_btn),
        .t          (t),
        .halted     (halted),
        .step_ready (step_ready),
        .instr_count(instr_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [5:0] model_t();
        logic [5:0] ring;
        ring = 6'b100000;
        if (m_halted) return 6'b000000;
        return ring >> m_tidx;
    endfunction

    task automatic model_reset();
        m_tidx     = 0;
        m_halted   = 1'b0;
        m_count    = 0;
        m_run_left = 0;
        m_level    = 1'b0;
        m_same     = 0;
        m_pulse    = 1'b0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit sample;
        bit pulse_now;
        bit adv;
        sample = m_hist.pop_front();
        m_hist.push_back(step_btn);
        pulse_now = m_pulse;
        m_pulse   = 1'b0;
        if (sample != m_level) begin
            m_same++;
            if (m_same == D) begin
                m_level = sample;
                m_same  = 0;
                m_pulse = sample;
            end
        end else begin
            m_same = 0;
        end

        if (!m_halted) begin
            if (m_tidx == 3 && !low_halt) begin
                m_halted   = 1'b1;
                m_run_left = 0;
            end else begin
                adv = 1'b0;
                if (m_run_left > 0 && mode != 2'b10) m_run_left = 0;
                if (m_run_left > 0) begin
                    adv = 1'b1;
                    m_run_left--;
                end else begin
                    case (mode)
                        2'b00: adv = 1'b1;
                        2'b01: adv = pulse_now;
                        2'b10: begin
                            if (pulse_now) begin
                                adv        = 1'b1;
                                m_run_left = 5 - m_tidx;
                            end
                        end
                        default: adv = 1'b0;
                    endcase
                end
                if (adv) begin
                    if (m_tidx == 5) m_count = (m_count + 1) % (1 << CW);
                    m_tidx = (m_tidx + 1) % 6;
                end
            end
        end
        exp_q.push_back(model_t());
    endtask

    task automatic compare_outputs();
        logic [5:0] e_t;
        bit         e_ready;
        e_t     = exp_q.pop_front();
        e_ready = ((mode == 2'b01) || (mode == 2'b10 && m_run_left == 0)) && !m_halted;
        check("t", t, e_t);
        check("halted", halted, m_halted);
        check("instr_count", instr_count, m_count);
        check("step_ready", step_ready, e_ready);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; inputs hold steady across the rising edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    // Asserts clr between clock edges and checks the outputs before any edge.
    task automatic reset_dut();
        #2;
        clr = 1'b0;
        model_reset();
        #1;
        check("rst_t", t, T1);
        check("rst_halted", halted, 1'b0);
        check("rst_count", instr_count, 0);
        check("rst_state", state_dbg, ACTIVE);
        @(negedge clk);
        clr = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        reset_dut();

        // Free run: two complete instructions in 12 edges
        repeat (12) cycle();
        check("run12_count", instr_count, 2);
        check("run12_t", t, T1);

        // HLT decoded at T4 freezes everything
        reset_dut();
        low_halt = 1'b0;
        repeat (3) cycle();
        check("pre_halt_t", t, T4);
        cycle();
        check("halt_t", t, T_IDLE);
        check("halt_flag", halted, 1'b1);
        for (int i = 0; i < 20; i++) begin
            mode     = 2'($urandom_range(0, 3));
            step_btn = 1'($urandom_range(0, 1));
            low_halt = 1'($urandom_range(0, 1));
            cycle();
        end
        check("halt_hold_t", t, T_IDLE);
        check("halt_hold_count", instr_count, 0);

        // T-step with a bouncing button: exactly one advance
        low_halt = 1'b1;
        step_btn = 1'b0;
        mode     = 2'b01;
        reset_dut();
        step_btn = 1'b1; #2 step_btn = 1'b0; #2 step_btn = 1'b1;
        cycle();
        step_btn = 1'b0; #2 step_btn = 1'b1; #2 step_btn = 1'b0;
        cycle();
        step_btn = 1'b1; #2 step_btn = 1'b0;
        cycle();
        step_btn = 1'b1;
        repeat (10) cycle();
        check("tstep_t", t, T2);
        step_btn = 1'b0;
        repeat (8) cycle();
        check("tstep_settle_t", t, T2);

        // Instruction step: one clean press runs a whole instruction
        mode = 2'b10;
        reset_dut();
        step_btn = 1'b1;
        repeat (D + 2) cycle();
        check("istep_wait_t", t, T1);
        cycle();
        check("istep_first_t", t, T2);
        check("istep_ready_run", step_ready, 1'b0);
        step_btn = 1'b0;
        repeat (5) cycle();
        check("istep_done_t", t, T1);
        check("istep_count", instr_count, 1);
        check("istep_ready_idle", step_ready, 1'b1);
        step_btn = 1'b1;
        repeat (3) cycle();
        step_btn = 1'b0;
        repeat (20) cycle();

        // Counter wrap in free run
        mode = 2'b00;
        reset_dut();
        repeat (255 * 6) cycle();
        check("wrap_pre_count", instr_count, 255);
        repeat (5) cycle();
        check("wrap_t6", t, T6);
        cycle();
        check("wrap_count", instr_count, 0);
        check("wrap_t", t, T1);

        // Asynchronous reset at T5 in the middle of an instruction-step run
        mode = 2'b10;
        reset_dut();
        step_btn = 1'b1;
        repeat (D + 3) cycle();
        step_btn = 1'b0;
        repeat (3) cycle();
        check("arst_pre_t", t, T5);
        check("arst_pre_state", state_dbg, INSTR_RUN);
        reset_dut();

        // Randomized mixed traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            low_halt = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            if (m_halted && $urandom_range(0, 20) == 0) reset_dut();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
